lmem_01_seq_ctrl: RTL and testbench

//  Control sequencer for the layer-0 to layer-1 L-memory stage. Issues per-cycle read

---
 rtl/lmem_01_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_lmem_01_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lmem_01_seq_ctrl.sv
// lmem_01_seq_ctrl: read/write slot sequencer for the layer-0 to layer-1 L-memory stage.
// Optional early termination on syndrome_ok is enabled by `define LMEM_SEQ_EARLYTERM_EN.
module lmem_01_seq_ctrl #(
    parameter int ADDRESSWIDTH = 5,
    parameter int NCYC         = 20,
    parameter int PIPE_LAT     = 6,
    parameter int ITRWIDTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ITRWIDTH-1:0]     max_iter,
`ifdef LMEM_SEQ_EARLYTERM_EN
    input  logic                    syndrome_ok,
`endif
    input  logic                    hold,
    output logic                    rd_en_o,
    output logic [ADDRESSWIDTH-1:0] rd_address_o,
    output logic                    wr_en_o,
    output logic [ADDRESSWIDTH-1:0] wr_address_o,
    output logic                    feedback_en_o,
    output logic [ITRWIDTH-1:0]     itr_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t                  state, state_n;
    logic [ADDRESSWIDTH-1:0] addr, addr_n;
    logic [ITRWIDTH-1:0]     max_q, max_n;
    logic [ITRWIDTH-1:0]     itr_n;
    logic                    rd_en_n, fb_n, busy_n, done_n;
    logic [ADDRESSWIDTH-1:0] rd_address_n;
    logic [ITRWIDTH:0]       itr_inc;
    logic                    last_itr, finish_now, pending;

    logic [PIPE_LAT-1:0]     dl_en;
    logic [ADDRESSWIDTH-1:0] dl_addr [PIPE_LAT];

    assign wr_en_o      = dl_en[PIPE_LAT-1];
    assign wr_address_o = dl_addr[PIPE_LAT-1];

    assign itr_inc  = {1'b0, itr_o} + 1'b1;
    assign last_itr = itr_inc >= {1'b0, max_q};

`ifdef LMEM_SEQ_EARLYTERM_EN
    assign finish_now = last_itr | syndrome_ok;
`else
    assign finish_now = last_itr;
`endif

    // Sweep is drained once only the write currently on wr_en_o remains.
    always_comb begin
        pending = rd_en_o;
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            pending = pending | dl_en[i];
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_n      = state;
        addr_n       = addr;
        max_n        = max_q;
        itr_n        = itr_o;
        rd_en_n      = 1'b0;
        rd_address_n = rd_address_o;
        fb_n         = feedback_en_o;
        busy_n       = busy_o;
        done_n       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    max_n   = (max_iter == '0) ? ITRWIDTH'(1) : max_iter;
                    itr_n   = '0;
                    addr_n  = '0;
                    fb_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    rd_en_n      = 1'b1;
                    rd_address_n = addr;
                    if (addr == ADDRESSWIDTH'(NCYC - 1)) begin
                        addr_n  = '0;
                        state_n = DRAIN;
                    end else begin
                        addr_n = addr + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!pending) begin
                    if (finish_now) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = FINISH;
                    end else begin
                        itr_n   = itr_inc[ITRWIDTH-1:0];
                        addr_n  = '0;
                        fb_n    = 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            max_q         <= '0;
            itr_o         <= '0;
            rd_en_o       <= 1'b0;
            rd_address_o  <= '0;
            feedback_en_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            state         <= state_n;
            addr          <= addr_n;
            max_q         <= max_n;
            itr_o         <= itr_n;
            rd_en_o       <= rd_en_n;
            rd_address_o  <= rd_address_n;
            feedback_en_o <= fb_n;
            busy_o        <= busy_n;
            done_o        <= done_n;
        end
    end

    // Fixed-latency copy of the read stream, stalls included, becomes the write stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_en <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_addr[i] <= '0;
            end
        end else begin
            dl_en      <= {dl_en[PIPE_LAT-2:0], rd_en_o};
            dl_addr[0] <= rd_address_o;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_lmem_01_seq_ctrl.sv
// tb_lmem_01_seq_ctrl: randomized bench for the L-memory sequencer.
// Define LMEM_SEQ_EARLYTERM_EN to also exercise early termination.
module tb_lmem_01_seq_ctrl;

    localparam int AW   = 5;
    localparam int NCYC = 20;
    localparam int PL   = 6;
    localparam int IW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] max_iter = '0;
    logic          hold = 1'b0;
`ifdef LMEM_SEQ_EARLYTERM_EN
    logic          syndrome_ok = 1'b0;
`endif
    logic          rd_en_o;
    logic [AW-1:0] rd_address_o;
    logic          wr_en_o;
    logic [AW-1:0] wr_address_o;
    logic          feedback_en_o;
    logic [IW-1:0] itr_o;
    logic          busy_o;
    logic          done_o;

    int n_cmp = 0;
    int n_bad = 0;

    lmem_01_seq_ctrl #(
        .ADDRESSWIDTH(AW),
        .NCYC(NCYC),
        .PIPE_LAT(PL),
        .ITRWIDTH(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .max_iter(max_iter),
`ifdef LMEM_SEQ_EARLYTERM_EN
        .syndrome_ok(syndrome_ok),
`endif
        .hold(hold),
        .rd_en_o(rd_en_o),
        .rd_address_o(rd_address_o),
        .wr_en_o(wr_en_o),
        .wr_address_o(wr_address_o),
        .feedback_en_o(feedback_en_o),
        .itr_o(itr_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en_o, 0);
        chk({tag, "_rd_addr"}, rd_address_o, 0);
        chk({tag, "_wr_en"}, wr_en_o, 0);
        chk({tag, "_wr_addr"}, wr_address_o, 0);
        chk({tag, "_fb"}, feedback_en_o, 0);
        chk({tag, "_itr"}, itr_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
    endtask

    // One decoding run checked against a sweep-level model.
    // hold_mode: 0 none, 1 random, 2 two-cycle stalls before addr 5 and 12.
    task automatic run_seq(input int mi, input int hold_mode,
                           input bit busy_start, input int abort_addr,
                           input int term_after);
        bit          rd_h [4096];
        logic [AW-1:0] ra_h [4096];
        int n, c, sweep, ea, outstanding, stalls, held_at, hc;
        int wr_cnt, done_cnt, busy_cnt;
        bit done, hold_app, mid;
        n = (mi == 0) ? 1 : mi;
        if (term_after >= 0) n = term_after + 1;
        start = 1'b1;
        max_iter = IW'(mi);
        hold = 1'b0;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy_o, 1);
        chk("itr_at_start", itr_o, 0);
        chk("fb_at_start", feedback_en_o, 0);
        c = 0;
        rd_h[0] = rd_en_o;
        ra_h[0] = rd_address_o;
        sweep = 0; ea = 0; outstanding = 0; stalls = 0;
        held_at = -1; hc = 0; done = 1'b0;
        while (!done && c < 3000) begin
            mid = (ea > 0) && (ea < NCYC) && (sweep < n);
            hold = 1'b0;
            if (mid && hold_mode == 1) hold = ($urandom_range(0, 4) == 0);
            if (mid && hold_mode == 2) begin
                if (ea == 5 || ea == 12) begin
                    if (held_at != ea) begin
                        held_at = ea;
                        hc = 0;
                    end
                    hold = (hc < 2);
                    if (hold) hc++;
                end else begin
                    held_at = -1;
                end
            end
            if (hold) stalls++;
            hold_app = hold && mid;
            if (busy_start && c == 10) begin
                start = 1'b1;
                max_iter = 4'd15;
            end
`ifdef LMEM_SEQ_EARLYTERM_EN
            syndrome_ok = (term_after >= 0) && (sweep == term_after + 1);
`endif
            tick();
            c++;
            start = 1'b0;
            if (abort_addr >= 0 && sweep == 0 && rd_en_o &&
                int'(rd_address_o) == abort_addr) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk_all_zero("abort");
                wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
                for (int k = 0; k < 30; k++) begin
                    tick();
                    wr_cnt += int'(wr_en_o);
                    done_cnt += int'(done_o);
                    busy_cnt += int'(busy_o);
                end
                chk("abort_wr_after", wr_cnt, 0);
                chk("abort_done_after", done_cnt, 0);
                chk("abort_busy_after", busy_cnt, 0);
                return;
            end
            rd_h[c] = rd_en_o;
            ra_h[c] = rd_address_o;
            if (c >= PL) begin
                chk("wr_en_lag", wr_en_o, rd_h[c-PL]);
                if (wr_en_o && rd_h[c-PL])
                    chk("wr_addr_lag", wr_address_o, ra_h[c-PL]);
            end else begin
                chk("wr_en_early", wr_en_o, 0);
            end
            if (wr_en_o) outstanding--;
            if (hold_app) chk("hold_gap", rd_en_o, 0);
            if (rd_en_o) begin
                chk("sweep_bound", sweep < n, 1);
                if (ea == 0 && sweep > 0)
                    chk("no_overlap", outstanding, 0);
                chk("rd_addr", rd_address_o, ea);
                chk("itr", itr_o, sweep);
                chk("fb", feedback_en_o, sweep > 0);
                outstanding++;
                ea++;
                if (ea == NCYC) begin
                    ea = 0;
                    sweep++;
                end
            end
            if (done_o) done = 1'b1;
        end
        chk("done_seen", done, 1);
        if (done) begin
            chk("busy_at_done", busy_o, 0);
            chk("sweeps", sweep, n);
            chk("outstanding", outstanding, 0);
            chk("itr_final", itr_o, n - 1);
            chk("latency_range",
                (c >= (NCYC + PL) * n + stalls) &&
                (c <= (NCYC + PL + 1) * n + stalls + 2), 1);
            tick();
            chk("done_one_pulse", done_o, 0);
            chk("busy_idle", busy_o, 0);
        end
`ifdef LMEM_SEQ_EARLYTERM_EN
        syndrome_ok = 1'b0;
`endif
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        max_iter = 4'd3;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("start_in_rst_busy", busy_o, 0);
        chk("start_in_rst_rd", rd_en_o, 0);
        repeat (2) tick();

        run_seq(1, 0, 1'b0, -1, -1);
        run_seq(3, 0, 1'b0, -1, -1);
        run_seq(2, 2, 1'b0, -1, -1);
        run_seq(0, 0, 1'b1, -1, -1);
        for (int r = 0; r < 4; r++) begin
            run_seq(int'($urandom_range(1, 3)), 1, 1'b0, -1, -1);
            repeat (int'($urandom_range(0, 3))) tick();
        end
        run_seq(3, 0, 1'b0, 9, -1);
        run_seq(1, 1, 1'b0, -1, -1);
`ifdef LMEM_SEQ_EARLYTERM_EN
        run_seq(5, 0, 1'b0, -1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
